iterative_shifter: RTL

- Multi-cycle, parametrised shifter for the MIPS datapath. Executes SLL, SRL, SRA and ROTR on a WIDTH-bit operand.
- Moves up to STEP bit positions per clock, trading latency for area.
- Sits beside the ALU and serves both shift-class instructions and branch-offset scaling (SLL by 2).
- Uses a start/busy/done handshake with the control unit.

---
 rtl/iterative_shifter_pkg.sv | 18 +
 rtl/shift_step.sv | 28 ++
 rtl/iterative_shifter.sv | 87 ++++++++
 3 files changed

// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes (also used by the ALU
// control decoder) and the controller states.
package iterative_shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k (0..STEP) positions per op.
// SRA fills vacated MSBs with the sign captured at start, not with the current MSB.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  sh_op_e           op,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    unique case (op)
      SH_SLL:  shifted = value << k;
      SH_SRL:  shifted = value >> k;
      SH_SRA:  shifted = WIDTH'({{WIDTH{sign}}, value} >> k);
      SH_ROTR: shifted = WIDTH'({value, value} >> k);
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR), up to STEP positions per clock.
// start/busy/done handshake; result only updates on the edge entering DONE.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int KW = $clog2(STEP + 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  sh_op_e           op_q;
  logic             sign_q;
  logic [SHW-1:0]   remaining, rem_nxt;
  logic [SHW:0]     rem_ext;
  logic [KW-1:0]    k;
  logic             accept, last;

  // STEP may equal WIDTH, which does not fit in SHW bits, so compare one bit wider.
  assign rem_ext = {1'b0, remaining};
  assign k       = (rem_ext >= (SHW+1)'(STEP)) ? KW'(STEP) : rem_ext[KW-1:0];
  assign rem_nxt = remaining - SHW'(k);
  assign last    = (rem_nxt == '0);
  assign accept  = start && (state != ST_SHIFT);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .value   (work),
    .k       (k),
    .op      (op_q),
    .sign    (sign_q),
    .shifted (work_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
        else        state_nxt = ST_IDLE;
      end
      ST_SHIFT: if (last) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work      <= '0;
      op_q      <= SH_SLL;
      sign_q    <= 1'b0;
      remaining <= '0;
      result    <= '0;
    end else if (accept) begin
      work      <= data_in;
      op_q      <= sh_op_e'(op);
      sign_q    <= data_in[WIDTH-1];
      remaining <= shamt;
      if (shamt == '0) result <= data_in;
    end else if (state == ST_SHIFT) begin
      work      <= work_nxt;
      remaining <= rem_nxt;
      if (last) result <= work_nxt;
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
